// File: rtl/pipelined_decode_stage.sv
// pipelined_decode_stage: RV32I decode with ID/EX register, load-use bubble and flush.
// Define RVM_EN to accept the M-extension R-type encodings (funct7=0000001).
module pipelined_decode_stage #(
  parameter int XLEN           = 32,
  parameter bit LOAD_USE_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_alu_op,
  output logic            out_reg_write,
  output logic            out_alu_src,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_mem_to_reg,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs1_f, rs2_f, rd_f;
  logic        s;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = in_instr[6:0];
  assign rd_f   = in_instr[11:7];
  assign f3     = in_instr[14:12];
  assign rs1_f  = in_instr[19:15];
  assign rs2_f  = in_instr[24:20];
  assign f7     = in_instr[31:25];
  assign s      = in_instr[31];

  assign imm_i = {{20{s}}, in_instr[31:20]};
  assign imm_s = {{20{s}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{s}}, s, in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{s}}, s, in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  logic        use1, use2, has_rd;
  logic [31:0] imm;
  logic [4:0]  alu_op;
  logic        reg_write, alu_src, mem_read, mem_write;
  logic        mem_to_reg, branch, jump, illegal;

  always_comb begin
    use1       = 1'b0;
    use2       = 1'b0;
    has_rd     = 1'b0;
    imm        = 32'd0;
    alu_op     = 5'd0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    illegal    = 1'b0;
    unique case (opcode)
      OP_R: begin
        use1      = 1'b1;
        use2      = 1'b1;
        has_rd    = 1'b1;
        reg_write = 1'b1;
        alu_op    = {1'b0, f7[5], f3};
        illegal   = 1'b1;
        if (f7 == 7'h00 ||
            (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)))
          illegal = 1'b0;
`ifdef RVM_EN
        if (f7 == 7'h01) begin
          illegal = 1'b0;
          alu_op  = {2'b10, f3};
        end
`endif
      end
      OP_IMM: begin
        use1      = 1'b1;
        has_rd    = 1'b1;
        alu_src   = 1'b1;
        reg_write = 1'b1;
        imm       = imm_i;
        alu_op    = (f3 == 3'b101) ? {1'b0, f7[5], f3} : {2'b00, f3};
        if (f3 == 3'b001 && f7 != 7'h00)
          illegal = 1'b1;
        if (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)
          illegal = 1'b1;
      end
      OP_LOAD: begin
        use1       = 1'b1;
        has_rd     = 1'b1;
        alu_src    = 1'b1;
        reg_write  = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        imm        = imm_i;
      end
      OP_STORE: begin
        use1      = 1'b1;
        use2      = 1'b1;
        alu_src   = 1'b1;
        mem_write = 1'b1;
        imm       = imm_s;
      end
      OP_BRANCH: begin
        use1   = 1'b1;
        use2   = 1'b1;
        branch = 1'b1;
        imm    = imm_b;
        alu_op = {2'b00, f3};
      end
      OP_JAL: begin
        has_rd    = 1'b1;
        jump      = 1'b1;
        reg_write = 1'b1;
        imm       = imm_j;
      end
      OP_JALR: begin
        use1      = 1'b1;
        has_rd    = 1'b1;
        jump      = 1'b1;
        alu_src   = 1'b1;
        reg_write = 1'b1;
        imm       = imm_i;
      end
      OP_LUI, OP_AUIPC: begin
        has_rd    = 1'b1;
        alu_src   = 1'b1;
        reg_write = 1'b1;
        imm       = imm_u;
      end
      default: illegal = 1'b1;
    endcase
    // Illegal entries still flow to EX, but must not touch state
    if (illegal) begin
      alu_op     = 5'd0;
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
    end
    if (rd_f == 5'd0)
      reg_write = 1'b0;
  end

  logic [4:0] rs1, rs2, rd;
  assign rs1 = use1 ? rs1_f : 5'd0;
  assign rs2 = use2 ? rs2_f : 5'd0;
  assign rd  = has_rd ? rd_f : 5'd0;

  logic advance, hazard, load_use, take;

  assign advance = !out_valid || out_ready;
  assign hazard  = out_valid && out_mem_read && (out_rd != 5'd0) &&
                   ((use1 && rs1_f == out_rd) ||
                    (use2 && rs2_f == out_rd));
  assign load_use = LOAD_USE_CHECK && in_valid && hazard;
  assign in_ready = advance && !load_use && !flush;
  assign take     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_rs1        <= '0;
      out_rs2        <= '0;
      out_rd         <= '0;
      out_imm        <= '0;
      out_funct3     <= '0;
      out_funct7     <= '0;
      out_alu_op     <= '0;
      out_reg_write  <= 1'b0;
      out_alu_src    <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      out_mem_to_reg <= 1'b0;
      out_branch     <= 1'b0;
      out_jump       <= 1'b0;
      out_illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= take;
      if (take) begin
        out_pc         <= in_pc;
        out_rs1        <= rs1;
        out_rs2        <= rs2;
        out_rd         <= rd;
        out_imm        <= XLEN'($signed(imm));
        out_funct3     <= f3;
        out_funct7     <= f7;
        out_alu_op     <= alu_op;
        out_reg_write  <= reg_write;
        out_alu_src    <= alu_src;
        out_mem_read   <= mem_read;
        out_mem_write  <= mem_write;
        out_mem_to_reg <= mem_to_reg;
        out_branch     <= branch;
        out_jump       <= jump;
        out_illegal    <= illegal;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// tb_pipelined_decode_stage: scoreboard bench with a field-level decode model.
// Build with RVM_EN defined to check the M-extension configuration.
`timescale 1ns/1ps
module tb_pipelined_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd, out_alu_op;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic        out_reg_write, out_alu_src, out_mem_read, out_mem_write;
  logic        out_mem_to_reg, out_branch, out_jump, out_illegal;

  pipelined_decode_stage #(.XLEN(32), .LOAD_USE_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_imm(out_imm),
    .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_alu_op(out_alu_op), .out_reg_write(out_reg_write),
    .out_alu_src(out_alu_src), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
    .out_branch(out_branch), .out_jump(out_jump),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  alu_op;
    logic rw, asrc, mr, mw, m2r, br, jmp, ill;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;
  logic [31:0] pcv = 32'h0000_1000;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference decode, written from the format tables with integer arithmetic
  function automatic exp_t model(logic [31:0] ins, logic [31:0] pc);
    exp_t e;
    int si, immi;
    int op, f3, f7;
    bit r1, r2, hrd, legal, known, m;
    e = '0;
    si = $signed(ins);
    op = int'(ins[6:0]);
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    immi = si >>> 20;
    r1 = 0; r2 = 0; hrd = 0; legal = 1; known = 1; m = 0;
    e.pc = pc;
    e.f3 = ins[14:12];
    e.f7 = ins[31:25];
    case (op)
      'h33: begin
        r1 = 1; r2 = 1; hrd = 1; e.rw = 1;
        legal = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
`ifdef RVM_EN
        if (f7 == 1) begin legal = 1; m = 1; end
`endif
        e.alu_op = 5'(f3 + (m ? 16 : 0) + ((f7 == 'h20) ? 8 : 0));
      end
      'h13: begin
        r1 = 1; hrd = 1; e.rw = 1; e.asrc = 1; e.imm = 32'(immi);
        if (f3 == 1) legal = (f7 == 0);
        if (f3 == 5) legal = (f7 == 0 || f7 == 'h20);
        e.alu_op = 5'(f3 + ((f3 == 5 && f7 == 'h20) ? 8 : 0));
      end
      'h03: begin
        r1 = 1; hrd = 1; e.rw = 1; e.asrc = 1; e.mr = 1; e.m2r = 1;
        e.imm = 32'(immi);
      end
      'h23: begin
        r1 = 1; r2 = 1; e.asrc = 1; e.mw = 1;
        e.imm = 32'(((si >>> 25) << 5) | int'(ins[11:7]));
      end
      'h63: begin
        r1 = 1; r2 = 1; e.br = 1; e.alu_op = 5'(f3);
        e.imm = 32'(((si >>> 31) << 12) | (int'(ins[7]) << 11) |
                    (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1));
      end
      'h6F: begin
        hrd = 1; e.jmp = 1; e.rw = 1;
        e.imm = 32'(((si >>> 31) << 20) | (int'(ins[19:12]) << 12) |
                    (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1));
      end
      'h67: begin
        r1 = 1; hrd = 1; e.jmp = 1; e.rw = 1; e.asrc = 1;
        e.imm = 32'(immi);
      end
      'h37, 'h17: begin
        hrd = 1; e.rw = 1; e.asrc = 1;
        e.imm = ins & 32'hFFFF_F000;
      end
      default: begin known = 0; legal = 0; end
    endcase
    if (known) begin
      e.rs1 = r1 ? ins[19:15] : 5'd0;
      e.rs2 = r2 ? ins[24:20] : 5'd0;
      e.rd  = hrd ? ins[11:7] : 5'd0;
    end
    if (!legal) begin
      e.ill = 1; e.alu_op = 0; e.rw = 0; e.asrc = 0; e.mr = 0;
      e.mw = 0; e.m2r = 0; e.br = 0; e.jmp = 0;
    end
    if (ins[11:7] == 0) e.rw = 0;
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t g;
    g = '{out_pc, out_rs1, out_rs2, out_rd, out_imm, out_funct3,
          out_funct7, out_alu_op, out_reg_write, out_alu_src,
          out_mem_read, out_mem_write, out_mem_to_reg, out_branch,
          out_jump, out_illegal};
    return g;
  endfunction

  // Monitor: retires held entries as EX takes them
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid) begin
      if (out_ready) begin
        if (q.size() == 0)
          chk("unexpected_out", 128'(out_valid), 128'(1'b0));
        else begin
          chk("entry", 128'(observed()), 128'(q[0]));
          void'(q.pop_front());
        end
      end else if (flush && q.size() != 0) begin
        void'(q.pop_front());
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] ins,
                      input logic fl, input logic ordy);
    exp_t m;
    logic lu, er;
    @(negedge clk);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pcv;
    flush     = fl;
    out_ready = ordy;
    #1;
    chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
    m  = model(ins, pcv);
    lu = v && q.size() != 0 && q[0].mr && q[0].rd != 0 &&
         (m.rs1 == q[0].rd || m.rs2 == q[0].rd);
    er = (q.size() == 0 || ordy) && !lu && !fl;
    chk("in_ready", 128'(in_ready), 128'(er));
    #2;
    if (v && er) q.push_back(m);
    pcv += 32'd4;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                           7'h6F, 7'h67, 7'h37, 7'h17};
    logic [6:0] op, f7;
    logic [31:0] ins;
    int k;
    k  = $urandom_range(0, 9);
    op = (k == 9) ? 7'($urandom) : ops[k];
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    ins = {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           3'($urandom), 5'($urandom_range(0, 3)), op};
    if ($urandom_range(0, 7) == 0) ins[31:7] = 25'($urandom);
    return ins;
  endfunction

  localparam logic [31:0] ADDI = 32'hFFF08293;
  localparam logic [31:0] LW   = 32'h00012183;
  localparam logic [31:0] ADD  = 32'h00118233;
  localparam logic [31:0] BEQ  = 32'hFE000EE3;
  localparam logic [31:0] JAL0 = 32'h0000006F;
  localparam logic [31:0] MUL  = 32'h02208033;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_instr = 32'h13; in_pc = 32'd0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_fields", 128'(observed()), 128'(0));
    rst = 1'b0;

    // addi x5,x1,-1
    step(1, ADDI, 0, 1);
    step(0, 32'h0, 0, 1);
    chk("addi_rd", 128'(out_rd), 128'(5));
    chk("addi_rs1", 128'(out_rs1), 128'(1));
    chk("addi_imm", 128'(out_imm), 128'(32'hFFFF_FFFF));
    chk("addi_ctl", 128'({out_alu_src, out_reg_write}), 128'(2'b11));

    // load-use: one bubble
    step(1, LW, 0, 1);
    step(1, ADD, 0, 1);
    chk("lu_stall", 128'(in_ready), 128'(1'b0));
    step(1, ADD, 0, 1);
    chk("lu_bubble", 128'(out_valid), 128'(1'b0));
    step(0, 32'h0, 0, 1);
    chk("lu_after", 128'(out_rd), 128'(4));

    // back-pressure for 3 cycles
    step(1, ADDI, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, ADD, 0, 0);
      chk("hold_rd", 128'(out_rd), 128'(5));
      chk("hold_imm", 128'(out_imm), 128'(32'hFFFF_FFFF));
    end
    step(1, ADD, 0, 1);
    chk("hold_release", 128'(in_ready), 128'(1'b1));
    step(0, 32'h0, 0, 1);

    // flush kills held entry and the presented one
    step(1, ADDI, 0, 1);
    step(1, ADD, 1, 0);
    step(0, 32'h0, 0, 1);
    chk("flush_valid", 128'(out_valid), 128'(1'b0));

    step(1, BEQ, 0, 1);
    step(1, JAL0, 0, 1);
    chk("beq_imm", 128'(out_imm), 128'(32'hFFFF_FFFC));
    chk("beq_branch", 128'(out_branch), 128'(1'b1));
    step(1, MUL, 0, 1);
    chk("jal_x0_rw", 128'(out_reg_write), 128'(1'b0));
    step(0, 32'h0, 0, 1);
`ifdef RVM_EN
    chk("mul_ill", 128'(out_illegal), 128'(1'b0));
    chk("mul_op", 128'(out_alu_op), 128'(5'b10000));
`else
    chk("mul_ill", 128'(out_illegal), 128'(1'b1));
`endif

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rand_instr(),
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    step(0, 32'h0, 0, 1);
    step(0, 32'h0, 0, 1);
    chk("drained", 128'(q.size()), 128'(0));

    // asynchronous reset while stalled
    step(1, ADDI, 0, 1);
    step(0, 32'h0, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_mid_rd", 128'(out_rd), 128'(0));
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(0, 32'h0, 0, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
